// File: rtl/mips54_pkg.sv
// mips54_pkg
//   Shared definitions for the multicycle MIPS core's shared-resource
//   arbitration.
//   - SEL_*       : one-hot select codes for the shared 4-input one-hot mux.
//                   SEL_NONE is the mux's high-Z default.
//   - arb_state_t : round-robin arbiter state.
package mips54_pkg;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL0     = 4'b0001;
    localparam logic [3:0] SEL1     = 4'b0010;
    localparam logic [3:0] SEL2     = 4'b0100;
    localparam logic [3:0] SEL3     = 4'b1000;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

endpackage : mips54_pkg

// File: rtl/rr_pick4.sv
// rr_pick4
//   Combinational round-robin selector for four requesters. It returns the
//   first set request bit, scanning ptr+1, ptr+2, ptr+3 and then ptr (mod 4).
//   Ports:
//     req    [3:0] in  : request vector
//     ptr    [1:0] in  : index of the most recent owner (lowest priority)
//     onehot [3:0] out : one-hot code of the winner, SEL_NONE if req == 0
//     idx    [1:0] out : binary index of the winner, 0 if req == 0
module rr_pick4
    import mips54_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] onehot,
    output logic [1:0] idx
);

    logic found;

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        onehot = SEL_NONE;
        idx    = 2'd0;
        found  = 1'b0;
        // k = 4 wraps to ptr itself, so the previous owner is scanned last.
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] cand;
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                idx    = cand;
                onehot = SEL0 << cand;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter sharing one 4-input resource between four requesters.
//   A grant is held for a whole transaction and is revoked by release,
//   withdrawal of the request, or a hold-time bound. At least one idle cycle
//   always separates two owners, so the one-hot select never jumps directly
//   between two codes. All outputs are registered.
//   Ports:
//     clk           in  : rising-edge clock
//     rst_n         in  : asynchronous active-low reset
//     iReq     [3:0] in : request levels, bit i = requester i
//     iRelease [3:0] in : end-of-transaction strobes, only the owner's bit counts
//     oGrant   [3:0] out: one-hot mux select, 4'b0000 when idle
//     oValid        out : oGrant != 0
//     oOwner   [1:0] out: index of current owner, holds last owner while idle
//     oTimeout      out : one-cycle pulse when a grant is forcibly revoked
module mux4_rr_arbiter
    import mips54_pkg::*;
#(
    parameter int HOLD_MAX  = 16,
    parameter int CNT_WIDTH = $clog2(HOLD_MAX)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] iReq,
    input  logic [3:0] iRelease,
    output logic [3:0] oGrant,
    output logic       oValid,
    output logic [1:0] oOwner,
    output logic       oTimeout
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(HOLD_MAX - 1);

    arb_state_t           state;
    logic [1:0]           ptr;
    logic [CNT_WIDTH-1:0] cnt;

    logic [3:0] pick_onehot;
    logic [1:0] pick_idx;

    rr_pick4 u_pick (
        .req    (iReq),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // End-of-tenure conditions, evaluated against the current owner only.
    logic owner_release;
    logic owner_withdraw;
    logic hold_expired;

    always_comb begin
        owner_release  = iRelease[oOwner];
        owner_withdraw = !iReq[oOwner];
        hold_expired   = (cnt == CNT_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            ptr      <= 2'd3;   // requester 0 is scanned first after reset
            cnt      <= '0;
            oGrant   <= SEL_NONE;
            oValid   <= 1'b0;
            oOwner   <= 2'd0;
            oTimeout <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    oTimeout <= 1'b0;
                    if (iReq != 4'b0000) begin
                        oGrant <= pick_onehot;
                        oValid <= 1'b1;
                        oOwner <= pick_idx;
                        ptr    <= pick_idx;
                        cnt    <= '0;
                        state  <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (owner_release || owner_withdraw || hold_expired) begin
                        oGrant   <= SEL_NONE;
                        oValid   <= 1'b0;
                        cnt      <= '0;
                        state    <= ARB_IDLE;
                        // A voluntary end in the same cycle wins over the bound.
                        oTimeout <= hold_expired && !owner_release && !owner_withdraw;
                    end else begin
                        oTimeout <= 1'b0;
                        if (cnt != CNT_LAST) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ARB_IDLE;
                    oGrant <= SEL_NONE;
                    oValid <= 1'b0;
                end
            endcase
        end
    end

endmodule : mux4_rr_arbiter

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter with HOLD_MAX = 16. Inputs change 1 ns
//   after each rising edge and outputs are checked at the same point.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] iReq;
    logic [3:0] iRelease;
    logic [3:0] oGrant;
    logic       oValid;
    logic [1:0] oOwner;
    logic       oTimeout;

    int tests  = 0;
    int failed = 0;

    mux4_rr_arbiter #(.HOLD_MAX(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iReq     (iReq),
        .iRelease (iRelease),
        .oGrant   (oGrant),
        .oValid   (oValid),
        .oOwner   (oOwner),
        .oTimeout (oTimeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks grant, valid (derived from the expected grant), owner and timeout.
    task automatic check_out(input string tag, input logic [3:0] g,
                             input logic [1:0] own, input logic to);
        check({tag, ".grant"},   oGrant,          g);
        check({tag, ".valid"},   {3'b0, oValid},  {3'b0, (g != 4'b0000)});
        check({tag, ".owner"},   {2'b0, oOwner},  {2'b0, own});
        check({tag, ".timeout"}, {3'b0, oTimeout}, {3'b0, to});
    endtask

    initial begin
        // Reset hold with every requester active.
        rst_n    = 1'b0;
        iReq     = 4'b1111;
        iRelease = 4'b0000;
        repeat (5) step();
        check_out("reset_hold", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("first_grant", 4'b0001, 2'd0, 1'b0);

        // Round-robin rotation, each owner releases on its 2nd grant cycle.
        for (int j = 0; j < 4; j++) begin
            logic [1:0] own;
            own = 2'(j);
            check_out("rot_c1", 4'b0001 << own, own, 1'b0);
            step();
            check_out("rot_c2", 4'b0001 << own, own, 1'b0);
            iRelease = 4'b0001 << own;
            step();
            iRelease = 4'b0000;
            check_out("rot_dead", 4'b0000, own, 1'b0);
            step();
        end
        check_out("rot_wrap", 4'b0001, 2'd0, 1'b0);

        // Non-owner release ignored; tenure must still end after 16 cycles,
        // which also shows the counter kept running during the ignored strobes.
        iRelease = 4'b0010;
        for (int c = 2; c <= 4; c++) begin
            step();
            check_out("nonowner_rel", 4'b0001, 2'd0, 1'b0);
        end
        iRelease = 4'b0000;
        for (int c = 5; c <= 16; c++) begin
            step();
            check_out("hold_1111", 4'b0001, 2'd0, 1'b0);
        end
        step();
        check_out("timeout_1111", 4'b0000, 2'd0, 1'b1);
        step();
        check_out("after_to_next", 4'b0010, 2'd1, 1'b0);

        // Release in the very first grant cycle: one-cycle tenure.
        iRelease = 4'b0010;
        step();
        iRelease = 4'b0000;
        check_out("rel_first_cycle", 4'b0000, 2'd1, 1'b0);

        // Timeout with a lone requester 2.
        iReq = 4'b0100;
        step();
        check_out("to2_c1", 4'b0100, 2'd2, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            step();
            check_out("to2_hold", 4'b0100, 2'd2, 1'b0);
        end
        step();
        check_out("to2_pulse", 4'b0000, 2'd2, 1'b1);
        step();
        check_out("to2_regrant", 4'b0100, 2'd2, 1'b0);

        // Requester 0 joins mid-tenure; after the timeout it wins.
        iReq = 4'b0101;
        for (int c = 2; c <= 16; c++) begin
            step();
            check_out("to2b_hold", 4'b0100, 2'd2, 1'b0);
        end
        step();
        check_out("to2b_pulse", 4'b0000, 2'd2, 1'b1);
        step();
        check_out("to2b_fair", 4'b0001, 2'd0, 1'b0);

        // Release coinciding with the final permitted cycle: no timeout pulse.
        for (int c = 2; c <= 16; c++) begin
            step();
            check_out("relto_hold", 4'b0001, 2'd0, 1'b0);
        end
        iRelease = 4'b0001;
        step();
        iRelease = 4'b0000;
        check_out("relto_end", 4'b0000, 2'd0, 1'b0);

        // Withdrawal by owner 3 while requester 1 waits.
        iReq = 4'b1000;
        step();
        check_out("wd_grant3", 4'b1000, 2'd3, 1'b0);
        iReq = 4'b0010;
        step();
        check_out("wd_dead", 4'b0000, 2'd3, 1'b0);
        step();
        check_out("wd_grant1", 4'b0010, 2'd1, 1'b0);

        // Async reset mid-grant while owner 3 holds the resource.
        iRelease = 4'b0010;
        step();
        iRelease = 4'b0000;
        iReq = 4'b1000;
        step();
        check_out("ar_grant3", 4'b1000, 2'd3, 1'b0);
        iReq = 4'b1001;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("ar_async", 4'b0000, 2'd0, 1'b0);
        step();
        check_out("ar_held", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("ar_restart", 4'b0001, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_mux4_rr_arbiter
